// File: rtl/freq_display_seq.sv
// Frequency display sequencer: latches a scaled count, converts it to BCD by double-dabble and
// scans hundreds, tens, units and exponent digits onto a single seven-segment display.
module freq_display_seq #(
  parameter int unsigned DWELL_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] freq_in,
  input  logic [1:0] sample_rate,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output logic       frame_start
);

  typedef enum logic [2:0] {
    StLoad,
    StConvert,
    StShowH,
    StShowT,
    StShowU,
    StShowE,
    StBlank
  } state_e;

  localparam logic [23:0] DwellLast = 24'(DWELL_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [23:0] r_dwell, w_dwell_d;
  logic [2:0]  r_bit_cnt, w_bit_cnt_d;
  logic [11:0] r_bcd, w_bcd_d, w_bcd_adj;
  logic [7:0]  r_shift, w_shift_d;
  logic [1:0]  r_rate, w_rate_d;
  logic        w_dwell_done;
  logic [3:0]  w_hund, w_tens, w_units, w_exp;

  function automatic logic [6:0] seg_pat(input logic [3:0] digit);
    logic [6:0] pat;
    pat = 7'h00;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  assign w_dwell_done = (r_dwell == DwellLast);

  // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_dwell_d   = r_dwell;
    w_bit_cnt_d = r_bit_cnt;
    w_bcd_d     = r_bcd;
    w_shift_d   = r_shift;
    w_rate_d    = r_rate;
    unique case (r_state)
      StLoad: begin
        w_shift_d   = freq_in;
        w_rate_d    = sample_rate;
        w_bcd_d     = '0;
        w_bit_cnt_d = '0;
        w_dwell_d   = '0;
        w_state_d   = StConvert;
      end
      StConvert: begin
        {w_bcd_d, w_shift_d} = {w_bcd_adj, r_shift} << 1;
        w_bit_cnt_d          = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) w_state_d = StShowH;
      end
      StShowH, StShowT, StShowU, StShowE, StBlank: begin
        if (w_dwell_done) begin
          w_dwell_d = '0;
          case (r_state)
            StShowH: w_state_d = StShowT;
            StShowT: w_state_d = StShowU;
            StShowU: w_state_d = StShowE;
            StShowE: w_state_d = StBlank;
            default: w_state_d = StLoad;
          endcase
        end else begin
          w_dwell_d = r_dwell + 24'd1;
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StLoad;
      r_dwell   <= '0;
      r_bit_cnt <= '0;
      r_bcd     <= '0;
      r_shift   <= '0;
      r_rate    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_dwell   <= w_dwell_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_bcd     <= w_bcd_d;
      r_shift   <= w_shift_d;
      r_rate    <= w_rate_d;
    end
  end

  assign w_hund  = r_bcd[11:8];
  assign w_tens  = r_bcd[7:4];
  assign w_units = r_bcd[3:0];
  assign w_exp   = 4'd5 - {2'b00, r_rate};

  always_comb begin
    seg = 7'h00;
    dp  = 1'b0;
    case (r_state)
      StShowH: if (w_hund != 4'd0) seg = seg_pat(w_hund);
      StShowT: if ((w_hund != 4'd0) || (w_tens != 4'd0)) seg = seg_pat(w_tens);
      StShowU: seg = seg_pat(w_units);
      StShowE: begin
        seg = seg_pat(w_exp);
        dp  = 1'b1;
      end
      default: seg = 7'h00;
    endcase
  end

  assign busy        = (r_state == StConvert);
  // State already sits in LOAD during reset; gate the pulse so it only shows once released.
  assign frame_start = (r_state == StLoad) && !reset;

endmodule

// File: tb/tb_freq_display_seq.sv
// Bench for freq_display_seq: per-cycle comparison of {frame_start, busy, dp, seg} against a
// frame model computed from decimal arithmetic on the latched value.
module tb_freq_display_seq;

  logic       clk;
  logic       reset, reset1;
  logic [7:0] freq_in;
  logic [1:0] sample_rate;
  logic [6:0] seg, seg1;
  logic       dp, dp1, busy, busy1, frame_start, frame_start1;

  int total = 0;
  int bad   = 0;

  freq_display_seq #(.DWELL_CYCLES(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .freq_in     (freq_in),
    .sample_rate (sample_rate),
    .seg         (seg),
    .dp          (dp),
    .busy        (busy),
    .frame_start (frame_start)
  );

  freq_display_seq #(.DWELL_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset1),
    .freq_in     (freq_in),
    .sample_rate (sample_rate),
    .seg         (seg1),
    .dp          (dp1),
    .busy        (busy1),
    .frame_start (frame_start1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int digit);
    logic [6:0] table_q [10];
    table_q = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return table_q[digit];
  endfunction

  // Expected {frame_start, busy, dp, seg} for cycle k of a frame showing value f at rate r.
  function automatic logic [9:0] exp_vec(input int k, input int f, input int r, input int d);
    int h, t, u;
    logic [6:0] s;
    logic p;
    h = f / 100;
    t = (f / 10) % 10;
    u = f % 10;
    s = 7'h00;
    p = 1'b0;
    if (k == 0) return 10'b10_0000_0000;
    if (k <= 8) return 10'b01_0000_0000;
    case ((k - 9) / d)
      0: s = (h == 0) ? 7'h00 : pat(h);
      1: s = (h == 0 && t == 0) ? 7'h00 : pat(t);
      2: s = pat(u);
      3: begin
        s = pat(5 - r);
        p = 1'b1;
      end
      default: s = 7'h00;
    endcase
    return {2'b00, p, s};
  endfunction

  function automatic logic [9:0] obs_vec(input int d);
    if (d == 1) return {frame_start1, busy1, dp1, seg1};
    return {frame_start, busy, dp, seg};
  endfunction

  task automatic check(input string tag, input int k, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Runs from the negedge before a LOAD cycle; alt<0 scrambles inputs after LOAD, else holds alt.
  task automatic run_frame(input string tag, input int f, input int r, input int d,
                           input int alt, input int stop_at);
    int len;
    len = 9 + 5 * d;
    for (int k = 0; k < len && k < stop_at; k++) begin
      if (k == 0) begin
        freq_in     = 8'(f);
        sample_rate = 2'(r);
      end else if (alt < 0) begin
        freq_in     = 8'($urandom);
        sample_rate = 2'($urandom);
      end else begin
        freq_in = 8'(alt);
      end
      #1;
      check(tag, k, obs_vec(d), exp_vec(k, f, r, d));
      @(negedge clk);
    end
  endtask

  initial begin
    int f, r;
    reset       = 1'b1;
    reset1      = 1'b1;
    freq_in     = 8'd0;
    sample_rate = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hold", 0, obs_vec(4), 10'h000);
    @(negedge clk);
    reset = 1'b0;

    run_frame("f123_r1", 123, 1, 4, -1, 1000);
    run_frame("f0_r0", 0, 0, 4, -1, 1000);
    run_frame("f255_r3", 255, 3, 4, -1, 1000);
    run_frame("f7_r2", 7, 2, 4, -1, 1000);
    run_frame("f40_chg", 40, 1, 4, 99, 1000);
    run_frame("f99_next", 99, 1, 4, -1, 1000);

    // Reset while SHOW_T is on display.
    run_frame("pre_rst", 57, 2, 4, -1, 14);
    reset = 1'b1;
    #1;
    check("rst_mid_now", 0, obs_vec(4), 10'h000);
    @(negedge clk);
    #1;
    check("rst_mid_held", 1, obs_vec(4), 10'h000);
    reset = 1'b0;
    run_frame("post_rst", 57, 2, 4, -1, 1000);
    run_frame("post_rst_next", 180, 0, 4, -1, 1000);

    for (int i = 0; i < 6; i++) begin
      f = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 3));
      run_frame("random", f, r, 4, -1, 1000);
    end

    @(negedge clk);
    reset1 = 1'b0;
    run_frame("dwell1_a", 208, 1, 1, -1, 1000);
    run_frame("dwell1_b", 5, 3, 1, -1, 1000);
    run_frame("dwell1_c", 90, 0, 1, -1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_display_seq.md
FREQ_DISPLAY_SEQ -- requirements
Module: freq_display_seq

Interface
REQ-001 The block SHALL have the parameter DWELL_CYCLES, default 2500000: clocks each display phase is held (0.25 s at 10 MHz); legal range 1 to 2^24-1.
REQ-002 The block SHALL have the port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have the port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have the port freq_in  input  8  scaled frequency count from the frequency decoder.
REQ-005 The block SHALL have the port sample_rate  input  2  same rate select the decoder uses (00=100 Hz, 01=1 kHz, 10=10 kHz, 11=100 kHz).
REQ-006 The block SHALL have the port seg  output  7  seven-segment pattern, active-high, seg[0]=a through seg[6]=g.
REQ-007 The block SHALL have the port dp  output  1  decimal point, active-high.
REQ-008 The block SHALL have the port busy  output  1  high while the BCD conversion runs.
REQ-009 The block SHALL have the port frame_start  output  1  one-cycle pulse in the LOAD cycle of each frame.

Function
REQ-010 The FSM SHALL use the states LOAD, CONVERT, SHOW_H, SHOW_T, SHOW_U, SHOW_E and BLANK, in that fixed cyclic order.
REQ-011 LOAD SHALL last 1 cycle: latch freq_in and sample_rate into internal registers, clear the 12-bit BCD accumulator and the bit counter, then go to CONVERT.
REQ-012 CONVERT SHALL last exactly 8 cycles, one double-dabble iteration per cycle: first add 3 to each BCD nibble that is >=5, then shift {bcd, shift_reg} left by 1; after the 8th cycle go to SHOW_H.
REQ-013 freq_in and sample_rate changes outside the LOAD cycle SHALL be ignored until the next frame.
REQ-014 Each of SHOW_H, SHOW_T, SHOW_U, SHOW_E and BLANK SHALL last exactly DWELL_CYCLES cycles, counted by a dwell counter that clears on every state change; BLANK then returns to LOAD.
REQ-015 Frame length SHALL be 9 + 5*DWELL_CYCLES cycles.
REQ-016 seg and dp SHALL be decoded combinationally from the registered state and registered digits, so the pattern changes in the same cycle the state changes.
REQ-017 Digit patterns SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; blank SHALL be 0x00.
REQ-018 SHOW_H SHALL show the hundreds digit, or blank when hundreds=0.
REQ-019 SHOW_T SHALL show the tens digit, or blank when both hundreds and tens=0.
REQ-020 SHOW_U SHALL always show the units digit, including 0.
REQ-021 SHOW_E SHALL show the exponent digit 5 - sample_rate (values 5, 4, 3, 2) with dp=1; dp SHALL be 0 in every other state.
REQ-022 In LOAD, CONVERT and BLANK, seg SHALL be 0x00.
REQ-023 busy SHALL be 1 exactly during the 8 CONVERT cycles.
REQ-024 frame_start SHALL be 1 only in the LOAD cycle.
REQ-025 The hundreds digit SHALL never exceed 2; BCD arithmetic SHALL be 4 bits per nibble with no carry out of the hundreds nibble.
REQ-026 The dwell counter SHALL be 24 bits and SHALL wrap only through the state change at DWELL_CYCLES-1.

Reset
REQ-027 While reset=1, the block SHALL force state to LOAD and clear the dwell counter, bit counter, BCD accumulator and latched inputs.
REQ-028 While reset=1, seg=0x00, dp=0, busy=0 and frame_start=0 SHALL hold.
REQ-029 Reset asserted mid-frame SHALL take effect immediately, with no completion of the current phase.
REQ-030 The first rising clk edge after reset release SHALL execute the LOAD cycle, so frame_start=1 in that cycle.

Verification (DWELL_CYCLES=4)
REQ-031 Directed test: freq_in=123, sample_rate=01 -> frame_start pulse; busy high for 8 cycles; then seg 0x06, 0x5B, 0x4F, and 0x66 with dp=1, each for 4 cycles; then 0x00 for 4 cycles; next frame_start 29 cycles after the first.
REQ-032 Directed test: freq_in=0, sample_rate=00 -> SHOW_H=0x00, SHOW_T=0x00, SHOW_U=0x3F, SHOW_E=0x6D with dp=1.
REQ-033 Directed test: freq_in=255, sample_rate=11 -> 0x5B, 0x6D, 0x6D, then 0x5B with dp=1; freq_in=7 -> 0x00, 0x00, 0x07.
REQ-034 Directed test: freq_in changed from 40 to 99 during CONVERT -> current frame shows blank, 4, 0; the next frame shows blank, 9, 9.
REQ-035 Directed test: reset pulsed during SHOW_T -> seg=0x00 and busy=0 immediately; after release, frame_start on the first edge, then a full 29-cycle frame.
REQ-036 Directed test: DWELL_CYCLES=1 -> each show/blank state lasts exactly 1 cycle; frame length = 14 cycles.
